branch_resolve_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu.sv | 36 +++
 rtl/branch_cond_decode.sv | 34 +++
 rtl/branch_resolve_unit.sv | 169 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and RV32 B-type funct3 values
// Contents:
//   alu_ctrl_codes : 4-bit ALU operation encoding shared by the ALU and its consumers
//   F3_*           : B-type branch funct3 encodings
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRS  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_USLT = 4'd9
  } alu_ctrl_codes;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit combinational ALU with zero flag
// Ports:
//   x, y  : operands
//   ctrl  : operation (alu_ctrl_codes)
//   f     : result
//   zero  : f == 0
module alu
  import alu_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [3:0]  ctrl,
  output logic [31:0] f,
  output logic        zero
);

  always_comb begin
    f = '0;
    case (ctrl)
      ALU_ADD:  f = x + y;
      ALU_SUB:  f = x - y;
      ALU_AND:  f = x & y;
      ALU_OR:   f = x | y;
      ALU_XOR:  f = x ^ y;
      ALU_SLL:  f = x << y[4:0];
      ALU_SRL:  f = x >> y[4:0];
      ALU_SRS:  f = $signed(x) >>> y[4:0];
      ALU_SLT:  f = {31'b0, $signed(x) < $signed(y)};
      ALU_USLT: f = {31'b0, x < y};
      default:  f = '0;
    endcase
  end

  assign zero = (f == 32'd0);

endmodule

// File: rtl/branch_cond_decode.sv
// rtl/branch_cond_decode.sv - B-type funct3 to ALU compare op and taken-polarity decode
// Ports:
//   funct3_i    : branch funct3
//   alu_ctrl_o  : ALU op that performs the comparison
//   invert_o    : taken is the complement of the selected flag
//   use_zero_o  : select ALU zero flag (else result bit 0)
//   illegal_o   : funct3 is not a branch encoding
module branch_cond_decode
  import alu_pkg::*;
(
  input  logic [2:0] funct3_i,
  output logic [3:0] alu_ctrl_o,
  output logic       invert_o,
  output logic       use_zero_o,
  output logic       illegal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    invert_o   = 1'b0;
    use_zero_o = 1'b0;
    illegal_o  = 1'b0;
    case (funct3_i)
      F3_BEQ:  begin alu_ctrl_o = ALU_SUB;  use_zero_o = 1'b1; end
      F3_BNE:  begin alu_ctrl_o = ALU_SUB;  use_zero_o = 1'b1; invert_o = 1'b1; end
      F3_BLT:  begin alu_ctrl_o = ALU_SLT;  end
      F3_BGE:  begin alu_ctrl_o = ALU_SLT;  invert_o = 1'b1; end
      F3_BLTU: begin alu_ctrl_o = ALU_USLT; end
      F3_BGEU: begin alu_ctrl_o = ALU_USLT; invert_o = 1'b1; end
      default: begin illegal_o  = 1'b1; end
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - multi-cycle conditional branch resolver driving an external ALU
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_*                          : branch request (valid/ready) with operands and prediction
//   alu_x/alu_y/alu_ctrl          : ALU drive from latched request
//   alu_f/alu_zero                : ALU result and zero flag
//   out_*                         : resolution response (valid/ready)
//   cnt_clr, branch_cnt, mispred_cnt : saturating statistics counters
module branch_resolve_unit
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_imm,
  input  logic             in_pred_taken,
  input  logic [31:0]      in_pred_target,
  output logic [31:0]      alu_x,
  output logic [31:0]      alu_y,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_f,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [31:0]      out_redirect_pc,
  output logic             out_illegal,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [31:0]      rs1_q, rs2_q, pc_q, imm_q, pred_target_q;
  logic             pred_taken_q;
  logic [3:0]       ctrl_q;
  logic             invert_q, use_zero_q, illegal_q;
  logic             taken_q, mispred_q, illegal_out_q;
  logic [31:0]      redirect_q;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [3:0]  dec_ctrl;
  logic        dec_invert, dec_use_zero, dec_illegal;
  logic        accept, eval;
  logic        cond, taken, mispred;
  logic [31:0] target, fallthrough, redirect;

  // Only bit 0 of the ALU result carries the SLT/USLT outcome.
  logic unused_alu_f;
  assign unused_alu_f = ^alu_f[31:1];

  // Decoding happens on the incoming funct3 so the latched ALU op is ADD
  // out of reset rather than whatever funct3 = 0 would decode to.
  branch_cond_decode u_decode (
    .funct3_i   (in_funct3),
    .alu_ctrl_o (dec_ctrl),
    .invert_o   (dec_invert),
    .use_zero_o (dec_use_zero),
    .illegal_o  (dec_illegal)
  );

  assign accept = (state_q == S_IDLE) && in_valid;
  assign eval   = (state_q == S_EVAL);

  assign alu_x    = rs1_q;
  assign alu_y    = rs2_q;
  assign alu_ctrl = ctrl_q;

  assign cond        = use_zero_q ? alu_zero : alu_f[0];
  assign taken       = !illegal_q && (cond ^ invert_q);
  assign target      = pc_q + imm_q;
  assign fallthrough = pc_q + 32'd4;
  assign redirect    = taken ? target : fallthrough;
  assign mispred     = !illegal_q &&
                       ((taken != pred_taken_q) ||
                        (taken && pred_taken_q && (pred_target_q != target)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_EVAL;
      S_EVAL:  state_d = S_RESP;
      S_RESP:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (cnt_clr) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else if (eval && !illegal_q) begin
      if (branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispred && (mispred_cnt_q != CNT_MAX)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rs1_q         <= '0;
      rs2_q         <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      ctrl_q        <= ALU_ADD;
      invert_q      <= 1'b0;
      use_zero_q    <= 1'b0;
      illegal_q     <= 1'b0;
      taken_q       <= 1'b0;
      mispred_q     <= 1'b0;
      illegal_out_q <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (accept) begin
        rs1_q         <= in_rs1;
        rs2_q         <= in_rs2;
        pc_q          <= in_pc;
        imm_q         <= in_imm;
        pred_taken_q  <= in_pred_taken;
        pred_target_q <= in_pred_target;
        ctrl_q        <= dec_ctrl;
        invert_q      <= dec_invert;
        use_zero_q    <= dec_use_zero;
        illegal_q     <= dec_illegal;
      end
      // Response registers only load in EVAL, so they stay frozen in RESP.
      if (eval) begin
        taken_q       <= taken;
        mispred_q     <= mispred;
        illegal_out_q <= illegal_q;
        redirect_q    <= redirect;
      end
    end
  end

  assign in_ready        = (state_q == S_IDLE);
  assign out_valid       = (state_q == S_RESP);
  assign out_taken       = taken_q;
  assign out_mispredict  = mispred_q;
  assign out_illegal     = illegal_out_q;
  assign out_redirect_pc = redirect_q;
  assign branch_cnt      = branch_cnt_q;
  assign mispred_cnt     = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed vector bench for branch_resolve_unit with the real ALU
module tb_branch_resolve_unit;
  import alu_pkg::*;

  localparam int CNT_W = 4;
  localparam int CNT_SAT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, in_ready, in_pred_taken;
  logic [2:0]       in_funct3;
  logic [31:0]      in_rs1, in_rs2, in_pc, in_imm, in_pred_target;
  logic [31:0]      alu_x, alu_y, alu_f;
  logic [3:0]       alu_ctrl;
  logic             alu_zero;
  logic             out_valid, out_ready, out_taken, out_mispredict, out_illegal;
  logic [31:0]      out_redirect_pc;
  logic             cnt_clr;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  branch_resolve_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl), .alu_f(alu_f), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_redirect_pc(out_redirect_pc), .out_illegal(out_illegal),
    .cnt_clr(cnt_clr), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  alu u_alu (.x(alu_x), .y(alu_y), .ctrl(alu_ctrl), .f(alu_f), .zero(alu_zero));

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_taken, e_mis;
    logic [31:0] e_red;
    logic        e_ill;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_br = 0;
  int exp_mp = 0;
  vec_t vecs[11];
  vec_t vsat;

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                              input logic [31:0] ptgt, input logic et, input logic em,
                              input logic [31:0] er, input logic ei);
    vec_t v;
    v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm; v.pt = pt; v.ptgt = ptgt;
    v.e_taken = et; v.e_mis = em; v.e_red = er; v.e_ill = ei;
    return v;
  endfunction

  function automatic logic [3:0] exp_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001: return 4'd1;
      3'b100, 3'b101: return 4'd8;
      3'b110, 3'b111: return 4'd9;
      default:        return 4'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, " branch_cnt"}, 32'(branch_cnt), 32'(exp_br));
    check({tag, " mispred_cnt"}, 32'(mispred_cnt), 32'(exp_mp));
  endtask

  task automatic drive(input vec_t v);
    in_funct3 = v.f3; in_rs1 = v.rs1; in_rs2 = v.rs2; in_pc = v.pc; in_imm = v.imm;
    in_pred_taken = v.pt; in_pred_target = v.ptgt; in_valid = 1'b1;
  endtask

  task automatic model_count(input vec_t v);
    if (!v.e_ill) begin
      if (exp_br < CNT_SAT) exp_br++;
      if (v.e_mis && exp_mp < CNT_SAT) exp_mp++;
    end
  endtask

  task automatic check_resp(input string tag, input vec_t v);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " out_taken"}, 32'(out_taken), 32'(v.e_taken));
    check({tag, " out_mispredict"}, 32'(out_mispredict), 32'(v.e_mis));
    check({tag, " out_redirect_pc"}, out_redirect_pc, v.e_red);
    check({tag, " out_illegal"}, 32'(out_illegal), 32'(v.e_ill));
  endtask

  // Accept one request and wait (bounded) for its response; leaves the DUT in RESP.
  task automatic issue(input string tag, input vec_t v);
    int cyc;
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    drive(v);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, " out_valid eval"}, 32'(out_valid), 32'd0);
    check({tag, " alu_x"}, alu_x, v.rs1);
    check({tag, " alu_y"}, alu_y, v.rs2);
    check({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'(exp_ctrl(v.f3)));
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd1);
    model_count(v);
    check_resp(tag, v);
    check_counters(tag);
  endtask

  task automatic release_resp(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, " out_valid after ack"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after ack"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(3'b000, 32'h5, 32'h5, 32'h1000, 32'h20, 1'b1, 32'h1020, 1'b1, 1'b0, 32'h1020, 1'b0);
    vecs[1]  = mk(3'b100, 32'hFFFFFFFF, 32'h1, 32'h3000, 32'h40, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3040, 1'b0);
    vecs[2]  = mk(3'b110, 32'hFFFFFFFF, 32'h1, 32'h3000, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h3004, 1'b0);
    vecs[3]  = mk(3'b001, 32'h1, 32'h2, 32'h2000, 32'hFFFFFFF0, 1'b1, 32'h2004, 1'b1, 1'b1, 32'h1FF0, 1'b0);
    vecs[4]  = mk(3'b101, 32'h1, 32'hFFFFFFFF, 32'h100, 32'h8, 1'b1, 32'h108, 1'b1, 1'b0, 32'h108, 1'b0);
    vecs[5]  = mk(3'b111, 32'h1, 32'hFFFFFFFF, 32'h100, 32'h8, 1'b1, 32'h108, 1'b0, 1'b1, 32'h104, 1'b0);
    vecs[6]  = mk(3'b000, 32'h1, 32'h2, 32'hFFFFFFFC, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vecs[7]  = mk(3'b010, 32'h0, 32'h0, 32'h500, 32'h10, 1'b1, 32'h510, 1'b0, 1'b0, 32'h504, 1'b1);
    vecs[8]  = mk(3'b011, 32'h3, 32'h3, 32'h520, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h524, 1'b1);
    vecs[9]  = mk(3'b001, 32'h7, 32'h7, 32'h600, 32'h30, 1'b1, 32'h630, 1'b0, 1'b1, 32'h604, 1'b0);
    vecs[10] = mk(3'b000, 32'h9, 32'h9, 32'hFFFFFFF0, 32'h20, 1'b1, 32'h10, 1'b1, 1'b0, 32'h10, 1'b0);
    vsat     = mk(3'b001, 32'h3, 32'h3, 32'h700, 32'h8, 1'b1, 32'h0, 1'b0, 1'b1, 32'h704, 1'b0);

    rst = 1'b1; in_valid = 1'b0; in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_pc = '0;
    in_imm = '0; in_pred_taken = 1'b0; in_pred_target = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_taken", 32'(out_taken), 32'd0);
    check("reset out_mispredict", 32'(out_mispredict), 32'd0);
    check("reset out_illegal", 32'(out_illegal), 32'd0);
    check("reset out_redirect_pc", out_redirect_pc, 32'd0);
    check("reset alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("reset alu_x", alu_x, 32'd0);
    check_counters("reset");

    for (int i = 0; i < 11; i++) begin
      issue($sformatf("vec%0d", i), vecs[i]);
      release_resp($sformatf("vec%0d", i));
    end

    // Backpressure: response held for 5 cycles, then a request offered during RESP is ignored.
    issue("bp", vecs[0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_resp("bp hold", vecs[0]);
      check("bp hold in_ready", 32'(in_ready), 32'd0);
    end
    drive(vecs[3]);
    out_ready = 1'b1;
    @(posedge clk);
    #1 begin in_valid = 1'b0; out_ready = 1'b0; end
    @(negedge clk);
    check("bp no accept in_ready", 32'(in_ready), 32'd1);
    check("bp no accept out_valid", 32'(out_valid), 32'd0);
    check_counters("bp after");

    // Reset while a branch is in EVAL drops it.
    @(negedge clk);
    drive(vecs[1]);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_br = 0;
    exp_mp = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst eval out_valid", 32'(out_valid), 32'd0);
    end
    check("rst eval in_ready", 32'(in_ready), 32'd1);
    check("rst eval alu_ctrl", 32'(alu_ctrl), 32'd0);
    check_counters("rst eval");

    // Saturation with 20 mispredicted branches.
    for (int i = 0; i < 20; i++) begin
      issue("sat", vsat);
      release_resp("sat");
    end
    check("sat branch_cnt", 32'(branch_cnt), 32'd15);
    check("sat mispred_cnt", 32'(mispred_cnt), 32'd15);

    // cnt_clr coincident with the EVAL->RESP increment wins.
    @(negedge clk);
    drive(vsat);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    exp_br = 0;
    exp_mp = 0;
    @(negedge clk);
    check("clr out_valid", 32'(out_valid), 32'd1);
    check("clr out_mispredict", 32'(out_mispredict), 32'd1);
    check_counters("clr");
    release_resp("clr");
    issue("post clr", vsat);
    release_resp("post clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
